// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: tracks in-flight destination registers in a
// DEPTH-slot shadow pipeline behind decode and derives stall/bubble/kill/forward.
module hazard_scoreboard #(
    parameter int  ADDR_W   = 5,
    parameter int  DEPTH    = 3,
    parameter int  FWD_EN   = 1,
    parameter int  LOAD_LAT = 1,
    parameter int  CNT_W    = 16,
    localparam int FWD_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_valid,
    input  logic [ADDR_W-1:0] de_rs1,
    input  logic [ADDR_W-1:0] de_rs2,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic [ADDR_W-1:0] de_rd,
    input  logic              de_rd_wen,
    input  logic              de_is_load,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              stall_de,
    output logic              bubble,
    output logic              de_kill,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [FWD_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam logic [FWD_W-1:0] LAT_K = FWD_W'(LOAD_LAT);

    logic [DEPTH:1]    slot_valid;
    logic [DEPTH:1]    slot_wen;
    logic [DEPTH:1]    slot_load;
    logic [ADDR_W-1:0] slot_rd [1:DEPTH];
    logic              flush_pend;

    logic              hit_a, hit_b, load_a, load_b;
    logic [FWD_W-1:0]  k_a, k_b;
    logic              haz_a, haz_b, haz, freeze, flush_eff, insert_bubble;

    // Scan oldest to youngest so the youngest matching slot is the one kept.
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        k_a    = '0;
        k_b    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (slot_valid[k] && slot_wen[k] && de_rs1_used &&
                (de_rs1 != '0) && (slot_rd[k] == de_rs1)) begin
                hit_a  = 1'b1;
                k_a    = FWD_W'(k);
                load_a = slot_load[k];
            end
            if (slot_valid[k] && slot_wen[k] && de_rs2_used &&
                (de_rs2 != '0) && (slot_rd[k] == de_rs2)) begin
                hit_b  = 1'b1;
                k_b    = FWD_W'(k);
                load_b = slot_load[k];
            end
        end
    end

    always_comb begin
        haz_a = (FWD_EN != 0) ? (hit_a && load_a && (k_a <= LAT_K)) : hit_a;
        haz_b = (FWD_EN != 0) ? (hit_b && load_b && (k_b <= LAT_K)) : hit_b;
        fwd_a = ((FWD_EN != 0) && hit_a && !haz_a) ? k_a : '0;
        fwd_b = ((FWD_EN != 0) && hit_b && !haz_b) ? k_b : '0;
    end

    assign haz       = de_valid && (haz_a || haz_b);
    assign freeze    = !mem_ready;
    assign flush_eff = flush || flush_pend;

    // Freeze outranks flush, which outranks a data hazard.
    always_comb begin
        stall_de      = 1'b0;
        bubble        = 1'b0;
        de_kill       = 1'b0;
        insert_bubble = 1'b0;
        if (freeze) begin
            stall_de = 1'b1;
        end else if (flush_eff) begin
            de_kill       = 1'b1;
            bubble        = 1'b1;
            insert_bubble = 1'b1;
        end else if (haz) begin
            stall_de      = 1'b1;
            bubble        = 1'b1;
            insert_bubble = 1'b1;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            occupancy = occupancy + FWD_W'(slot_valid[k]);
        end
    end

    // Slots only move on unfrozen edges; the pending flush and counter always update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_valid   <= '0;
            slot_wen     <= '0;
            slot_load    <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                slot_rd[k] <= '0;
            end
            flush_pend   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (stall_de && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (freeze) begin
                if (flush) begin
                    flush_pend <= 1'b1;
                end
            end else begin
                flush_pend <= 1'b0;
                for (int k = DEPTH; k >= 2; k--) begin
                    slot_valid[k] <= slot_valid[k-1];
                    slot_wen[k]   <= slot_wen[k-1];
                    slot_load[k]  <= slot_load[k-1];
                    slot_rd[k]    <= slot_rd[k-1];
                end
                slot_valid[1] <= de_valid && !insert_bubble;
                slot_wen[1]   <= de_rd_wen;
                slot_load[1]  <= de_is_load;
                slot_rd[1]    <= de_rd;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one forwarding instance and one stall-only
// instance (CNT_W=2) share inputs; directed tables plus a randomized reference model.
module tb_hazard_scoreboard;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int FWD_W    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              de_valid;
    logic [ADDR_W-1:0] de_rs1, de_rs2, de_rd;
    logic              de_rs1_used, de_rs2_used, de_rd_wen, de_is_load;
    logic              flush, mem_ready;

    logic              stall0, bubble0, kill0, stall1, bubble1, kill1;
    logic [FWD_W-1:0]  fwda0, fwdb0, occ0, fwda1, fwdb1, occ1;
    logic [15:0]       cnt0;
    logic [1:0]        cnt1;

    hazard_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FWD_EN(1), .LOAD_LAT(LOAD_LAT), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
        .de_rd_wen(de_rd_wen), .de_is_load(de_is_load), .flush(flush), .mem_ready(mem_ready),
        .stall_de(stall0), .bubble(bubble0), .de_kill(kill0), .fwd_a(fwda0), .fwd_b(fwdb0),
        .occupancy(occ0), .stall_cycles(cnt0)
    );

    hazard_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FWD_EN(0), .LOAD_LAT(LOAD_LAT), .CNT_W(2)) u_nofwd (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
        .de_rd_wen(de_rd_wen), .de_is_load(de_is_load), .flush(flush), .mem_ready(mem_ready),
        .stall_de(stall1), .bubble(bubble1), .de_kill(kill1), .fwd_a(fwda1), .fwd_b(fwdb1),
        .occupancy(occ1), .stall_cycles(cnt1)
    );

    typedef struct {
        bit inst;
        bit valid;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit wen;
        bit load;
        bit fl;
        bit mrdy;
        bit e_stall;
        bit e_bub;
        bit e_kill;
        int e_fa;
        int e_fb;
        int e_occ;
        int e_cnt;
    } vec_t;

    typedef struct {
        bit valid;
        int rd;
        bit wen;
        bit load;
    } entry_t;

    vec_t   tbl_fwd[$];
    vec_t   tbl_nofwd[$];
    entry_t m_slot [0:1][1:DEPTH];
    bit     m_pend [0:1];
    int     m_cnt  [0:1];
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int cnt_max(input int inst);
        return (inst == 0) ? 65535 : 3;
    endfunction

    // Youngest in-flight writer of rs decides forwarding or hazard.
    function automatic void eval_operand(input int inst, input int rs, input bit used,
                                         output bit haz, output int fwd);
        int k_hit = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k_hit == 0 && used && rs != 0 && m_slot[inst][k].valid &&
                m_slot[inst][k].wen && m_slot[inst][k].rd == rs)
                k_hit = k;
        end
        haz = 1'b0;
        fwd = 0;
        if (k_hit != 0) begin
            if (inst == 0) begin
                haz = m_slot[inst][k_hit].load && (k_hit <= LOAD_LAT);
                fwd = haz ? 0 : k_hit;
            end else begin
                haz = 1'b1;
            end
        end
    endfunction

    function automatic void model_outputs(input int inst, output bit stall, output bit bub,
                                          output bit kill, output int fa, output int fb,
                                          output int occ);
        bit ha, hb;
        eval_operand(inst, int'(de_rs1), de_rs1_used, ha, fa);
        eval_operand(inst, int'(de_rs2), de_rs2_used, hb, fb);
        stall = 1'b0;
        bub   = 1'b0;
        kill  = 1'b0;
        if (!mem_ready) stall = 1'b1;
        else if (flush || m_pend[inst]) begin
            kill = 1'b1;
            bub  = 1'b1;
        end else if (de_valid && (ha || hb)) begin
            stall = 1'b1;
            bub   = 1'b1;
        end
        occ = 0;
        for (int k = 1; k <= DEPTH; k++) occ += int'(m_slot[inst][k].valid);
    endfunction

    function automatic void model_update(input int inst);
        bit stall, bub, kill;
        int fa, fb, occ;
        entry_t e;
        model_outputs(inst, stall, bub, kill, fa, fb, occ);
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) m_slot[inst][k] = '{0, 0, 0, 0};
            m_pend[inst] = 1'b0;
            m_cnt[inst]  = 0;
            return;
        end
        if (stall && m_cnt[inst] < cnt_max(inst)) m_cnt[inst]++;
        if (!mem_ready) begin
            if (flush) m_pend[inst] = 1'b1;
        end else begin
            for (int k = DEPTH; k >= 2; k--) m_slot[inst][k] = m_slot[inst][k-1];
            e.valid = de_valid && !bub;
            e.rd    = int'(de_rd);
            e.wen   = de_rd_wen;
            e.load  = de_is_load;
            m_slot[inst][1] = e;
            m_pend[inst]    = 1'b0;
        end
    endfunction

    task automatic get_dut(input int inst, output logic [31:0] o[7]);
        if (inst == 0) begin
            o[0] = {31'b0, stall0}; o[1] = {31'b0, bubble0}; o[2] = {31'b0, kill0};
            o[3] = {30'b0, fwda0};  o[4] = {30'b0, fwdb0};   o[5] = {30'b0, occ0};
            o[6] = {16'b0, cnt0};
        end else begin
            o[0] = {31'b0, stall1}; o[1] = {31'b0, bubble1}; o[2] = {31'b0, kill1};
            o[3] = {30'b0, fwda1};  o[4] = {30'b0, fwdb1};   o[5] = {30'b0, occ1};
            o[6] = {30'b0, cnt1};
        end
    endtask

    task automatic check_model();
        bit s, b, kl;
        int fa, fb, occ;
        logic [31:0] o[7];
        for (int inst = 0; inst < 2; inst++) begin
            model_outputs(inst, s, b, kl, fa, fb, occ);
            get_dut(inst, o);
            cmp($sformatf("model i%0d stall_de", inst), o[0], 32'(s));
            cmp($sformatf("model i%0d bubble", inst), o[1], 32'(b));
            cmp($sformatf("model i%0d de_kill", inst), o[2], 32'(kl));
            cmp($sformatf("model i%0d fwd_a", inst), o[3], fa);
            cmp($sformatf("model i%0d fwd_b", inst), o[4], fb);
            cmp($sformatf("model i%0d occupancy", inst), o[5], occ);
            cmp($sformatf("model i%0d stall_cycles", inst), o[6], m_cnt[inst]);
        end
    endtask

    // Called just after a negedge with inputs stable; ends on the next negedge.
    task automatic finish_cycle(input bit do_check);
        if (do_check) check_model();
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_stimulus(input vec_t v);
        de_valid    = v.valid;
        de_rs1      = ADDR_W'(v.rs1);
        de_rs2      = ADDR_W'(v.rs2);
        de_rs1_used = v.u1;
        de_rs2_used = v.u2;
        de_rd       = ADDR_W'(v.rd);
        de_rd_wen   = v.wen;
        de_is_load  = v.load;
        flush       = v.fl;
        mem_ready   = v.mrdy;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        logic [31:0] o[7];
        get_dut(int'(v.inst), o);
        cmp($sformatf("row%0d i%0d stall_de", idx, v.inst), o[0], 32'(v.e_stall));
        cmp($sformatf("row%0d i%0d bubble", idx, v.inst), o[1], 32'(v.e_bub));
        cmp($sformatf("row%0d i%0d de_kill", idx, v.inst), o[2], 32'(v.e_kill));
        cmp($sformatf("row%0d i%0d fwd_a", idx, v.inst), o[3], v.e_fa);
        cmp($sformatf("row%0d i%0d fwd_b", idx, v.inst), o[4], v.e_fb);
        cmp($sformatf("row%0d i%0d occupancy", idx, v.inst), o[5], v.e_occ);
        cmp($sformatf("row%0d i%0d stall_cycles", idx, v.inst), o[6], v.e_cnt);
    endtask

    task automatic randomize_inputs();
        de_valid    = 1'($urandom_range(0, 1));
        de_rs1      = ADDR_W'($urandom_range(0, 7));
        de_rs2      = ADDR_W'($urandom_range(0, 7));
        de_rs1_used = 1'($urandom_range(0, 1));
        de_rs2_used = 1'($urandom_range(0, 1));
        de_rd       = ADDR_W'($urandom_range(0, 7));
        de_rd_wen   = 1'($urandom_range(0, 1));
        de_is_load  = ($urandom_range(0, 3) == 0);
        flush       = ($urandom_range(0, 9) == 0);
        mem_ready   = ($urandom_range(0, 4) != 0);
    endtask

    task automatic do_reset();
        logic [31:0] o[7];
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            #1;
            finish_cycle(1'b0);
        end
        rst = 1'b1;
        apply_stimulus('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        #1;
        for (int inst = 0; inst < 2; inst++) begin
            get_dut(inst, o);
            for (int j = 0; j < 7; j++) cmp($sformatf("reset i%0d out%0d", inst, j), o[j], 32'd0);
        end
        finish_cycle(1'b1);
    endtask

    initial begin
        // inst valid rs1 rs2 u1 u2 rd wen load flush mrdy | stall bub kill fa fb occ cnt
        tbl_fwd.push_back('{0, 1, 1, 2, 0, 0, 5, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0});
        tbl_fwd.push_back('{0, 1, 5, 5, 1, 1, 6, 1, 0, 0, 1,  0, 0, 0, 1, 1, 1, 0});
        tbl_fwd.push_back('{0, 1, 5, 0, 1, 0, 9, 1, 0, 0, 1,  0, 0, 0, 2, 0, 2, 0});
        tbl_fwd.push_back('{0, 1, 2, 0, 1, 0, 7, 1, 1, 0, 1,  0, 0, 0, 0, 0, 3, 0});
        tbl_fwd.push_back('{0, 1, 7, 0, 1, 1, 8, 1, 0, 0, 1,  1, 1, 0, 0, 0, 3, 0});
        tbl_fwd.push_back('{0, 1, 7, 0, 1, 1, 8, 1, 0, 0, 1,  0, 0, 0, 2, 0, 2, 1});
        tbl_fwd.push_back('{0, 1, 3, 4, 1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1});
        tbl_fwd.push_back('{0, 1, 0, 8, 1, 0, 10, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2, 1});
        tbl_fwd.push_back('{0, 1, 10, 0, 1, 0, 11, 1, 0, 1, 0, 1, 0, 0, 0, 0, 3, 1});
        tbl_fwd.push_back('{0, 1, 10, 0, 1, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 2});
        tbl_fwd.push_back('{0, 1, 10, 0, 1, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 3});
        tbl_fwd.push_back('{0, 1, 10, 0, 1, 0, 11, 1, 0, 0, 1, 0, 1, 1, 0, 0, 3, 4});
        tbl_fwd.push_back('{0, 1, 10, 0, 1, 0, 11, 1, 0, 0, 1, 0, 0, 0, 2, 0, 2, 4});

        tbl_nofwd.push_back('{1, 1, 1, 2, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        for (int i = 0; i < 3; i++)
            tbl_nofwd.push_back('{1, 1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, i});
        tbl_nofwd.push_back('{1, 1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3});
        for (int i = 0; i < 3; i++)
            tbl_nofwd.push_back('{1, 1, 6, 0, 1, 0, 7, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 3});
        tbl_nofwd.push_back('{1, 1, 6, 0, 1, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3});

        do_reset();
        foreach (tbl_fwd[i]) begin
            apply_stimulus(tbl_fwd[i]);
            #1;
            check_output(i, tbl_fwd[i]);
            finish_cycle(1'b1);
        end

        do_reset();
        foreach (tbl_nofwd[i]) begin
            apply_stimulus(tbl_nofwd[i]);
            #1;
            check_output(100 + i, tbl_nofwd[i]);
            finish_cycle(1'b1);
        end

        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 49) != 0);
            #1;
            finish_cycle(1'b1);
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
